// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the stream-fed sequence detector.
package seq_det_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned PAT_W_DEF  = 4;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/pat_det_moore.sv
// Moore pattern detector: serial history window, fill count and a registered
// match pulse. hit_c flags a window match on the current shift edge.
module pat_det_moore #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clr,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pat,
    input  logic             ovl,
    output logic             hit_c,
    output logic             match
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;

    // Window after this edge's bit; fill saturates once the window is full.
    always_comb begin
        hist_nxt = {hist[PAT_W-2:0], bit_in};
        fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + FILL_W'(1);
        hit_c    = shift_en && (fill_nxt == FILL_W'(PAT_W)) && (hist_nxt == pat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (clr) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= hit_c;
            if (shift_en) begin
                hist <= hist_nxt;
                // Non-overlapping mode restarts the window after a hit.
                fill <= (hit_c && !ovl) ? '0 : fill_nxt;
            end
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// Word-stream front end for the pattern detector: handshake, MSB-first
// serializer, configuration, saturating match counter and sticky interrupt.
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned PAT_W  = PAT_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic              cfg_ovl,
    input  logic [CNT_W-1:0]  cfg_thr,
    output logic              cfg_err,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              bit_vld,
    output logic              bit_out,
    output logic              match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              irq,
    input  logic              irq_clr,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  idx;
    logic [PAT_W-1:0]  pat_q;
    logic              ovl_q;
    logic [CNT_W-1:0]  thr_q;

    logic              cfg_clr;
    logic              accept;
    logic              hit_c;
    logic              cnt_sat;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              irq_set;

    assign busy    = (state == SHIFT);
    assign bit_vld = (state == SHIFT);
    assign bit_out = shreg[DATA_W-1];
    assign accept  = in_valid && in_ready;
    assign cfg_clr = cfg_we && (state == IDLE);

    // Serializer FSM; in_ready is precomputed for the cycle after each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            in_ready <= 1'b1;
        end else if (state == IDLE) begin
            if (accept) begin
                shreg    <= in_data;
                idx      <= IDX_W'(DATA_W - 1);
                state    <= SHIFT;
                in_ready <= 1'b0;
            end
        end else if (idx == '0) begin
            if (accept) begin
                shreg    <= in_data;
                idx      <= IDX_W'(DATA_W - 1);
                in_ready <= 1'b0;
            end else begin
                // Shifting the last bit out leaves bit_out low while idle.
                shreg    <= shreg << 1;
                state    <= IDLE;
                in_ready <= 1'b1;
            end
        end else begin
            shreg    <= shreg << 1;
            idx      <= idx - IDX_W'(1);
            in_ready <= (idx == IDX_W'(1));
        end
    end

    // Configuration is only accepted between words; a write mid-word is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= '0;
            ovl_q   <= 1'b1;
            thr_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (state == SHIFT);
            if (cfg_clr) begin
                pat_q <= cfg_pat;
                ovl_q <= cfg_ovl;
                thr_q <= cfg_thr;
            end
        end
    end

    pat_det_moore #(
        .PAT_W (PAT_W)
    ) u_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (bit_vld),
        .clr      (cfg_clr),
        .bit_in   (bit_out),
        .pat      (pat_q),
        .ovl      (ovl_q),
        .hit_c    (hit_c),
        .match    (match)
    );

    assign cnt_sat = &match_cnt;
    assign cnt_nxt = match_cnt + CNT_W'(1);
    // Interrupt only fires on an actual count step onto the threshold.
    assign irq_set = hit_c && !cnt_sat && (thr_q != '0) && (cnt_nxt == thr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            irq       <= 1'b0;
        end else if (cfg_clr) begin
            match_cnt <= '0;
            irq       <= 1'b0;
        end else begin
            if (hit_c && !cnt_sat) begin
                match_cnt <= cnt_nxt;
            end
            if (irq_set) begin
                irq <= 1'b1;
            end else if (irq_clr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_stream_ctrl.sv
// Scoreboard bench: driver feeds words into a bit-stream reference model that
// queues per-bit expectations; a negedge monitor pops and compares.
module tb_seq_det_stream_ctrl;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned PAT_W  = 4;
    localparam int unsigned CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pat;
    logic              cfg_ovl;
    logic [CNT_W-1:0]  cfg_thr;
    logic              cfg_err;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              bit_vld;
    logic              bit_out;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic              irq;
    logic              irq_clr;
    logic              busy;

    seq_det_stream_ctrl #(
        .DATA_W (DATA_W),
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_ovl   (cfg_ovl),
        .cfg_thr   (cfg_thr),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .bit_vld   (bit_vld),
        .bit_out   (bit_out),
        .match     (match),
        .match_cnt (match_cnt),
        .irq       (irq),
        .irq_clr   (irq_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             b;
        logic             hit;
        logic [CNT_W-1:0] cnt;
        logic             irq_set;
        logic             last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: raw bit stream since the last clear point.
    logic             m_bits[$];
    logic [PAT_W-1:0] r_pat;
    logic             r_ovl;
    logic [CNT_W-1:0] r_thr;
    logic [CNT_W-1:0] r_cnt;

    logic dir_clr;
    logic rnd_clr;
    logic rnd_en;
    logic cfg_bad;
    assign irq_clr = dir_clr | rnd_clr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset(input logic [PAT_W-1:0] p, input logic o,
                                        input logic [CNT_W-1:0] t);
        r_pat = p;
        r_ovl = o;
        r_thr = t;
        r_cnt = '0;
        m_bits.delete();
    endfunction

    function automatic void model_word(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) begin
            exp_t        e;
            logic [31:0] val;
            e.b = w[i];
            m_bits.push_back(w[i]);
            if (m_bits.size() > 16) void'(m_bits.pop_front());
            e.hit = 1'b0;
            if (m_bits.size() >= PAT_W) begin
                val = '0;
                for (int j = PAT_W; j >= 1; j--)
                    val = (val << 1) | 32'(m_bits[m_bits.size() - j]);
                e.hit = (val == 32'(r_pat));
            end
            e.irq_set = 1'b0;
            if (e.hit) begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt     = r_cnt + CNT_W'(1);
                    e.irq_set = (r_thr != '0) && (r_cnt == r_thr);
                end
                if (!r_ovl) m_bits.delete();
            end
            e.cnt  = r_cnt;
            e.last = (i == 0);
            exp_q.push_back(e);
        end
    endfunction

    // Monitor state
    exp_t             pend;
    logic             have_pend = 1'b0;
    logic             m_irq = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_clr_prev = 1'b0;
    logic             m_cfg_prev = 1'b0;
    logic             m_err_next = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_bit_vld", 32'(bit_vld), 32'd0);
            chk("rst_bit_out", 32'(bit_out), 32'd0);
            chk("rst_match", 32'(match), 32'd0);
            chk("rst_match_cnt", 32'(match_cnt), 32'd0);
            chk("rst_irq", 32'(irq), 32'd0);
            chk("rst_cfg_err", 32'(cfg_err), 32'd0);
            exp_q.delete();
            have_pend  = 1'b0;
            m_irq      = 1'b0;
            m_cnt      = '0;
            m_clr_prev = 1'b0;
            m_cfg_prev = 1'b0;
            m_err_next = 1'b0;
        end else begin
            if (have_pend) begin
                m_cnt = pend.cnt;
                chk("match", 32'(match), 32'(pend.hit));
            end else begin
                if (m_cfg_prev) m_cnt = '0;
                chk("match_idle", 32'(match), 32'd0);
            end
            if (have_pend && pend.irq_set) m_irq = 1'b1;
            else if (m_cfg_prev || m_clr_prev) m_irq = 1'b0;
            chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
            chk("irq", 32'(irq), 32'(m_irq));
            chk("cfg_err", 32'(cfg_err), 32'(m_err_next));
            chk("bit_vld", 32'(bit_vld), 32'(exp_q.size() != 0));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            have_pend = 1'b0;
            if (exp_q.size() != 0) begin
                pend      = exp_q.pop_front();
                have_pend = 1'b1;
                chk("bit_out", 32'(bit_out), 32'(pend.b));
                chk("in_ready", 32'(in_ready), 32'(pend.last));
            end else begin
                chk("in_ready_idle", 32'(in_ready), 32'd1);
            end
            m_clr_prev = irq_clr;
            m_cfg_prev = cfg_we && !cfg_bad;
            m_err_next = cfg_we && cfg_bad;
        end
    end

    always @(posedge clk) begin
        #1;
        rnd_clr = rnd_en && ($urandom_range(0, 7) == 0);
    end

    task automatic send_word(input logic [DATA_W-1:0] w);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1 t=%0t", $time);
        end else begin
            model_word(w);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 t=%0t", exp_q.size(), $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [PAT_W-1:0] p, input logic o, input logic [CNT_W-1:0] t);
        wait_idle();
        cfg_we  = 1'b1;
        cfg_pat = p;
        cfg_ovl = o;
        cfg_thr = t;
        @(posedge clk);
        model_reset(p, o, t);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_pat  = '0;
        cfg_ovl  = 1'b0;
        cfg_thr  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        dir_clr  = 1'b0;
        rnd_clr  = 1'b0;
        rnd_en   = 1'b0;
        cfg_bad  = 1'b0;
        model_reset('0, 1'b1, '0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Overlapping 1010 on AA: hits after bits 3, 5, 7
        cfg_write(4'b1010, 1'b1, 8'd0);
        send_word(8'hAA);
        wait_idle();
        chk("ovl_aa_cnt", 32'(match_cnt), 32'd3);

        // Non-overlapping 1010 on AA: hits after bits 3, 7
        cfg_write(4'b1010, 1'b0, 8'd0);
        send_word(8'hAA);
        wait_idle();
        chk("novl_aa_cnt", 32'(match_cnt), 32'd2);

        // Pattern spans a word boundary, words back-to-back
        cfg_write(4'b1010, 1'b0, 8'd0);
        send_word(8'h05);
        send_word(8'h40);
        wait_idle();
        chk("cross_word_cnt", 32'(match_cnt), 32'd1);

        // Threshold 2: clear coinciding with the setting match loses
        cfg_write(4'b1010, 1'b1, 8'd2);
        send_word(8'hAA);
        repeat (5) @(posedge clk);
        #1 dir_clr = 1'b1;
        @(posedge clk);
        #1 dir_clr = 1'b0;
        chk("irq_set_wins", 32'(irq), 32'd1);
        repeat (2) @(posedge clk);
        #1 dir_clr = 1'b1;
        @(posedge clk);
        #1 dir_clr = 1'b0;
        chk("irq_cleared", 32'(irq), 32'd0);
        chk("irq_cnt", 32'(match_cnt), 32'd3);
        wait_idle();

        // Config write mid-word is rejected
        cfg_write(4'b1010, 1'b1, 8'd0);
        send_word(8'hAA);
        @(posedge clk);
        #1;
        cfg_bad = 1'b1;
        cfg_we  = 1'b1;
        cfg_pat = 4'b0110;
        cfg_ovl = 1'b0;
        cfg_thr = 8'd1;
        @(posedge clk);
        #1;
        cfg_we  = 1'b0;
        cfg_bad = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        @(posedge clk);
        #1;
        chk("cfg_err_drop", 32'(cfg_err), 32'd0);
        wait_idle();
        chk("cfg_reject_cnt", 32'(match_cnt), 32'd3);

        // Reset mid-word after the first hit; history must restart empty
        cfg_write(4'b1010, 1'b1, 8'd0);
        send_word(8'hAA);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_cnt", 32'(match_cnt), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        model_reset('0, 1'b1, '0);
        #1;
        chk("rst_async_cnt", 32'(match_cnt), 32'd0);
        chk("rst_async_vld", 32'(bit_vld), 32'd0);
        chk("rst_async_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_word(8'h0F);
        wait_idle();
        chk("post_rst_cnt", 32'(match_cnt), 32'd1);

        // Counter saturation with threshold at all-ones, no re-set once saturated
        cfg_write(4'b1010, 1'b1, 8'hFF);
        for (int k = 0; k < 66; k++) send_word(8'hAA);
        wait_idle();
        chk("sat_cnt", 32'(match_cnt), 32'd255);
        chk("sat_irq", 32'(irq), 32'd1);
        dir_clr = 1'b1;
        @(posedge clk);
        #1 dir_clr = 1'b0;
        send_word(8'hAA);
        send_word(8'hAA);
        wait_idle();
        chk("sat_irq_stays_clr", 32'(irq), 32'd0);
        chk("sat_cnt_hold", 32'(match_cnt), 32'd255);

        // Randomized configurations, words, gaps and interrupt clears
        rnd_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            cfg_write(PAT_W'($urandom), 1'($urandom), CNT_W'($urandom_range(0, 8)));
            for (int w = 0; w < 12; w++) begin
                int gap;
                gap = $urandom_range(0, 3);
                if (gap != 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
                send_word(DATA_W'($urandom));
            end
        end
        rnd_en = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
